// File: rtl/rs_issue_select.sv
// Issue select: round-robin pick of one ready RS entry per cycle,
// gating its operands off the shared buses into a registered FU latch.
module rs_issue_select #(
  parameter int NUM_RS   = 8,
  parameter int PRN_BITS = 6,
  parameter int ROB_BITS = 5,
  parameter int IDX_BITS = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_RS-1:0]            rs_ready_in,
  input  logic [NUM_RS*5-1:0]          rs_func_in,
  input  logic [NUM_RS*PRN_BITS-1:0]   rs_prn_in,
  input  logic [NUM_RS*ROB_BITS-1:0]   rs_rob_in,
  input  logic [63:0]                  rs_opa_bus,
  input  logic [63:0]                  rs_opb_bus,
  output logic [NUM_RS-1:0]            rs_use_enable,
  output logic [NUM_RS-1:0]            rs_free,
  input  logic                         fu_ready,
  input  logic                         flush,
  output logic                         fu_valid,
  output logic [63:0]                  fu_opa,
  output logic [63:0]                  fu_opb,
  output logic [4:0]                   fu_func,
  output logic [PRN_BITS-1:0]          fu_prn,
  output logic [ROB_BITS-1:0]          fu_rob,
  output logic [IDX_BITS-1:0]          fu_rs_idx
);

  logic [IDX_BITS-1:0] r_rr_ptr;
  logic                r_fu_valid;
  logic [63:0]         r_opa;
  logic [63:0]         r_opb;
  logic [4:0]          r_func;
  logic [PRN_BITS-1:0] r_prn;
  logic [ROB_BITS-1:0] r_rob;
  logic [IDX_BITS-1:0] r_idx;

  logic                w_can_issue;
  logic                w_found;
  logic [IDX_BITS-1:0] w_gidx;
  logic [IDX_BITS-1:0] w_cand;
  logic                w_issue;
  logic [NUM_RS-1:0]   w_grant;
  logic [4:0]          w_func;
  logic [PRN_BITS-1:0] w_prn;
  logic [ROB_BITS-1:0] w_rob;

  assign w_can_issue = !flush && (!r_fu_valid || fu_ready);

  // Scan starts at the pointer; index arithmetic wraps since NUM_RS is 2^IDX_BITS.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      w_cand = r_rr_ptr + IDX_BITS'(k);
      if (!w_found && rs_ready_in[w_cand]) begin
        w_found = 1'b1;
        w_gidx  = w_cand;
      end
    end
  end

  assign w_issue = w_can_issue && w_found && !reset;

  always_comb begin
    w_grant = '0;
    if (w_issue)
      w_grant = NUM_RS'(1) << w_gidx;
  end

  assign rs_use_enable = w_grant;
  assign rs_free       = w_grant;

  always_comb begin
    w_func = '0;
    w_prn  = '0;
    w_rob  = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (w_gidx == IDX_BITS'(i)) begin
        w_func = rs_func_in[5*i +: 5];
        w_prn  = rs_prn_in[PRN_BITS*i +: PRN_BITS];
        w_rob  = rs_rob_in[ROB_BITS*i +: ROB_BITS];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_ptr   <= '0;
      r_fu_valid <= 1'b0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_func     <= '0;
      r_prn      <= '0;
      r_rob      <= '0;
      r_idx      <= '0;
    end else if (w_issue) begin
      r_rr_ptr   <= w_gidx + IDX_BITS'(1);
      r_fu_valid <= 1'b1;
      r_opa      <= rs_opa_bus;
      r_opb      <= rs_opb_bus;
      r_func     <= w_func;
      r_prn      <= w_prn;
      r_rob      <= w_rob;
      r_idx      <= w_gidx;
    end else if (flush || fu_ready) begin
      r_fu_valid <= 1'b0;
    end
  end

  assign fu_valid  = r_fu_valid;
  assign fu_opa    = r_opa;
  assign fu_opb    = r_opb;
  assign fu_func   = r_func;
  assign fu_prn    = r_prn;
  assign fu_rob    = r_rob;
  assign fu_rs_idx = r_idx;

endmodule

// File: tb/tb_rs_issue_select.sv
// Bench for rs_issue_select: vector table, directed corner sequences,
// and random traffic against a behavioural model of the issue rules.
module tb_rs_issue_select;
  localparam int N = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic [7:0]   rs_ready_in;
  logic [39:0]  rs_func_in;
  logic [47:0]  rs_prn_in;
  logic [39:0]  rs_rob_in;
  logic [63:0]  rs_opa_bus;
  logic [63:0]  rs_opb_bus;
  logic [7:0]   rs_use_enable;
  logic [7:0]   rs_free;
  logic         fu_ready;
  logic         flush;
  logic         fu_valid;
  logic [63:0]  fu_opa;
  logic [63:0]  fu_opb;
  logic [4:0]   fu_func;
  logic [5:0]   fu_prn;
  logic [4:0]   fu_rob;
  logic [2:0]   fu_rs_idx;

  logic [4:0]  func_arr [N];
  logic [5:0]  prn_arr  [N];
  logic [4:0]  rob_arr  [N];
  logic [63:0] opa_arr  [N];
  logic [63:0] opb_arr  [N];

  int n_vec = 0;
  int n_bad = 0;

  int          m_rr;
  bit          m_valid;
  logic [63:0] m_opa, m_opb;
  logic [4:0]  m_func;
  logic [5:0]  m_prn;
  logic [4:0]  m_rob;
  int          m_idx;
  int          m_g;

  typedef struct {
    logic [7:0] ready;
    logic       fr;
    logic       fl;
    logic [7:0] exp_gnt;
    logic       exp_vld;
    logic [2:0] exp_idx;
  } vec_t;
  vec_t tbl [16];

  rs_issue_select dut (
    .clock(clock), .reset(reset),
    .rs_ready_in(rs_ready_in), .rs_func_in(rs_func_in),
    .rs_prn_in(rs_prn_in), .rs_rob_in(rs_rob_in),
    .rs_opa_bus(rs_opa_bus), .rs_opb_bus(rs_opb_bus),
    .rs_use_enable(rs_use_enable), .rs_free(rs_free),
    .fu_ready(fu_ready), .flush(flush), .fu_valid(fu_valid),
    .fu_opa(fu_opa), .fu_opb(fu_opb), .fu_func(fu_func),
    .fu_prn(fu_prn), .fu_rob(fu_rob), .fu_rs_idx(fu_rs_idx)
  );

  always #5 clock = ~clock;

  always_comb begin
    rs_func_in = '0;
    rs_prn_in  = '0;
    rs_rob_in  = '0;
    rs_opa_bus = '0;
    rs_opb_bus = '0;
    for (int i = 0; i < N; i++) begin
      rs_func_in[5*i +: 5] = func_arr[i];
      rs_prn_in[6*i +: 6]  = prn_arr[i];
      rs_rob_in[5*i +: 5]  = rob_arr[i];
      if (rs_use_enable[i]) begin
        rs_opa_bus = rs_opa_bus | opa_arr[i];
        rs_opb_bus = rs_opb_bus | opb_arr[i];
      end
    end
  end

  always @(negedge clock)
    if (!reset)
      assert ($onehot0(rs_use_enable))
        else $error("FAIL onehot grant=%b", rs_use_enable);

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_valid = 0; m_idx = 0; m_g = -1;
    m_opa = '0; m_opb = '0; m_func = '0; m_prn = '0; m_rob = '0;
  endtask

  task automatic model_check();
    logic [7:0] eg;
    bit can;
    can = !flush && (!m_valid || fu_ready);
    m_g = -1;
    if (can)
      for (int k = 0; k < N; k++)
        if (m_g < 0 && rs_ready_in[(m_rr + k) % N])
          m_g = (m_rr + k) % N;
    eg = '0;
    if (m_g >= 0) eg[m_g] = 1'b1;
    chk("use_enable", rs_use_enable, eg);
    chk("rs_free", rs_free, eg);
    chk("fu_valid", fu_valid, m_valid);
    if (m_valid) begin
      chk("fu_opa", fu_opa, m_opa);
      chk("fu_opb", fu_opb, m_opb);
      chk("fu_func", fu_func, m_func);
      chk("fu_prn", fu_prn, m_prn);
      chk("fu_rob", fu_rob, m_rob);
      chk("fu_rs_idx", fu_rs_idx, m_idx);
    end
  endtask

  task automatic model_update();
    if (m_g >= 0) begin
      m_opa = opa_arr[m_g]; m_opb = opb_arr[m_g];
      m_func = func_arr[m_g]; m_prn = prn_arr[m_g];
      m_rob = rob_arr[m_g]; m_idx = m_g;
      m_valid = 1; m_rr = (m_g + 1) % N;
    end else if (flush || fu_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic step();
    #2;
    model_check();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, fu_valid, 0);
    chk({tag, "_opa"}, fu_opa, 0);
    chk({tag, "_opb"}, fu_opb, 0);
    chk({tag, "_func"}, fu_func, 0);
    chk({tag, "_prn"}, fu_prn, 0);
    chk({tag, "_rob"}, fu_rob, 0);
    chk({tag, "_idx"}, fu_rs_idx, 0);
    chk({tag, "_gnt"}, rs_use_enable, 0);
    chk({tag, "_free"}, rs_free, 0);
  endtask

  logic [7:0] rdy;

  initial begin
    tbl[0]  = '{8'b1000_0011, 1, 0, 8'b0000_0001, 0, 3'd0};
    tbl[1]  = '{8'b1000_0011, 1, 0, 8'b0000_0010, 1, 3'd0};
    tbl[2]  = '{8'b1000_0011, 1, 0, 8'b1000_0000, 1, 3'd1};
    tbl[3]  = '{8'b1000_0011, 1, 0, 8'b0000_0001, 1, 3'd7};
    tbl[4]  = '{8'b1000_0011, 1, 0, 8'b0000_0010, 1, 3'd0};
    tbl[5]  = '{8'b0000_0000, 1, 0, 8'b0000_0000, 1, 3'd1};
    tbl[6]  = '{8'b0000_0000, 0, 0, 8'b0000_0000, 0, 3'd1};
    tbl[7]  = '{8'b0001_0010, 1, 0, 8'b0001_0000, 0, 3'd1};
    tbl[8]  = '{8'b0000_0010, 1, 0, 8'b0000_0010, 1, 3'd4};
    tbl[9]  = '{8'b0000_0000, 1, 0, 8'b0000_0000, 1, 3'd1};
    tbl[10] = '{8'b0000_0000, 1, 0, 8'b0000_0000, 0, 3'd1};
    tbl[11] = '{8'b0100_0000, 1, 0, 8'b0100_0000, 0, 3'd1};
    tbl[12] = '{8'b0100_0000, 1, 1, 8'b0000_0000, 1, 3'd6};
    tbl[13] = '{8'b1100_0001, 0, 0, 8'b1000_0000, 0, 3'd6};
    tbl[14] = '{8'b0000_0000, 0, 0, 8'b0000_0000, 1, 3'd7};
    tbl[15] = '{8'b0000_0000, 1, 0, 8'b0000_0000, 1, 3'd7};

    for (int i = 0; i < N; i++) begin
      func_arr[i] = 5'(i + 3);
      prn_arr[i]  = 6'(i * 5 + 1);
      rob_arr[i]  = 5'(i * 3 + 2);
      opa_arr[i]  = 64'h1000 + 64'(i);
      opb_arr[i]  = 64'h2000 + 64'(i);
    end
    rs_ready_in = '0; fu_ready = 0; flush = 0;
    reset = 1;
    model_reset();
    repeat (2) @(negedge clock);
    #1 chk_reset_state("por");
    @(negedge clock);
    reset = 0;

    for (int i = 0; i < 16; i++) begin
      rs_ready_in = tbl[i].ready;
      fu_ready    = tbl[i].fr;
      flush       = tbl[i].fl;
      #1;
      chk($sformatf("tbl%0d_gnt", i), rs_use_enable, tbl[i].exp_gnt);
      chk($sformatf("tbl%0d_vld", i), fu_valid, tbl[i].exp_vld);
      chk($sformatf("tbl%0d_idx", i), fu_rs_idx, tbl[i].exp_idx);
      step();
    end

    opa_arr[3] = 64'hA; opb_arr[3] = 64'hB;
    rs_ready_in = 8'b0000_1000; fu_ready = 1;
    step();
    rs_ready_in = 8'b0010_0000; fu_ready = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("stall_gnt", rs_use_enable, 0);
      chk("stall_opa", fu_opa, 64'hA);
      chk("stall_opb", fu_opb, 64'hB);
      chk("stall_idx", fu_rs_idx, 3);
      step();
    end
    fu_ready = 1;
    #1 chk("unstall_gnt", rs_use_enable, 8'b0010_0000);
    step();
    rs_ready_in = '0;
    #1 chk("unstall_idx", fu_rs_idx, 5);
    step();

    func_arr[2] = 5'h13; prn_arr[2] = 6'h2A; rob_arr[2] = 5'h11;
    opa_arr[2] = 64'hDEAD_BEEF;
    rs_ready_in = 8'b0000_0100; fu_ready = 1;
    step();
    rs_ready_in = '0; fu_ready = 0;
    #1;
    chk("pl_func", fu_func, 5'h13);
    chk("pl_prn", fu_prn, 6'h2A);
    chk("pl_rob", fu_rob, 5'h11);
    chk("pl_opa", fu_opa, 64'hDEAD_BEEF);
    step();

    rs_ready_in = 8'hFF;
    #2 chk("pre_rst_vld", fu_valid, 1);
    reset = 1;
    #1 chk_reset_state("mid");
    model_reset();
    @(negedge clock);
    reset = 0;
    rs_ready_in = 8'b0000_0100; fu_ready = 1;
    #1 chk("rel_gnt", rs_use_enable, 8'b0000_0100);
    step();
    rs_ready_in = '0;
    #1 chk("rel_idx", fu_rs_idx, 2);
    step();

    rdy = '0;
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < N; j++)
        if (!rdy[j] && $urandom_range(0, 2) == 0) begin
          rdy[j] = 1'b1;
          func_arr[j] = 5'($urandom);
          prn_arr[j]  = 6'($urandom);
          rob_arr[j]  = 5'($urandom);
          opa_arr[j]  = {$urandom, $urandom};
          opb_arr[j]  = {$urandom, $urandom};
        end
      rs_ready_in = rdy;
      fu_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 12) == 0);
      step();
      if (m_g >= 0) rdy[m_g] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
